// File: rtl/seq_divider_if.sv
// Operand and result stream bundle between the divide requester and seq_divider.
interface seq_divider_if #(
  parameter int WIDTH = 64
);
  logic               s_axis_dividend_tvalid;
  logic [WIDTH-1:0]   s_axis_dividend_tdata;
  logic               s_axis_dividend_tready;
  logic               s_axis_divisor_tvalid;
  logic [WIDTH-1:0]   s_axis_divisor_tdata;
  logic               s_axis_divisor_tready;
  logic               m_axis_dout_tvalid;
  logic [2*WIDTH-1:0] m_axis_dout_tdata;
  logic               m_axis_dout_tuser;

  modport master (
    output s_axis_dividend_tvalid, s_axis_dividend_tdata,
    output s_axis_divisor_tvalid, s_axis_divisor_tdata,
    input  s_axis_dividend_tready, s_axis_divisor_tready,
    input  m_axis_dout_tvalid, m_axis_dout_tdata, m_axis_dout_tuser
  );

  modport slave (
    input  s_axis_dividend_tvalid, s_axis_dividend_tdata,
    input  s_axis_divisor_tvalid, s_axis_divisor_tdata,
    output s_axis_dividend_tready, s_axis_divisor_tready,
    output m_axis_dout_tvalid, m_axis_dout_tdata, m_axis_dout_tuser
  );
endinterface

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring unsigned divider, one quotient bit per cycle.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | accepting operand beats into the one-entry channel buffers
// CALC  | WIDTH shift/subtract iterations, operand channels closed
// DONE  | one-cycle result strobe on m_axis_dout_tvalid
module seq_divider #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 7
) (
  input logic         Clk,
  input logic         resetn,
  seq_divider_if.slave dif
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state, state_nxt;
  logic               dvd_full, dvs_full;
  logic [WIDTH-1:0]   dvd_buf, dvs_buf;
  logic [WIDTH-1:0]   dvs_reg, rem, quo;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] dout_data;
  logic               dout_zero;

  logic               dvd_rdy, dvs_rdy, dvd_acc, dvs_acc, start, last_iter;
  logic [WIDTH-1:0]   dvd_val, dvs_val, rem_nxt, quo_nxt;
  logic [WIDTH:0]     trial, diff;

  // Handshake, operand forwarding and next-state decode.
  always_comb begin
    dvd_rdy   = !dvd_full && (state == IDLE);
    dvs_rdy   = !dvs_full && (state == IDLE);
    dvd_acc   = dif.s_axis_dividend_tvalid && dvd_rdy;
    dvs_acc   = dif.s_axis_divisor_tvalid && dvs_rdy;
    // A beat arriving on the same edge as the other buffer filling still starts the run.
    dvd_val   = dvd_full ? dvd_buf : dif.s_axis_dividend_tdata;
    dvs_val   = dvs_full ? dvs_buf : dif.s_axis_divisor_tdata;
    start     = (state == IDLE) && (dvd_full || dvd_acc) && (dvs_full || dvs_acc);
    last_iter = (cnt == CNT_W'(WIDTH - 1));
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (last_iter) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One restoring step; a zero divisor needs no special case.
  always_comb begin
    trial = {rem, quo[WIDTH-1]};
    diff  = trial - {1'b0, dvs_reg};
    if (trial >= {1'b0, dvs_reg}) begin
      rem_nxt = diff[WIDTH-1:0];
      quo_nxt = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_nxt = trial[WIDTH-1:0];
      quo_nxt = {quo[WIDTH-2:0], 1'b0};
    end
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Operand buffers, iteration datapath and held result.
  always_ff @(posedge Clk) begin
    if (!resetn) begin
      dvd_full  <= 1'b0;
      dvs_full  <= 1'b0;
      dvd_buf   <= '0;
      dvs_buf   <= '0;
      dvs_reg   <= '0;
      rem       <= '0;
      quo       <= '0;
      cnt       <= '0;
      dout_data <= '0;
      dout_zero <= 1'b0;
    end else begin
      if (start) begin
        dvd_full <= 1'b0;
        dvs_full <= 1'b0;
        rem      <= '0;
        quo      <= dvd_val;
        dvs_reg  <= dvs_val;
        cnt      <= '0;
      end else begin
        if (dvd_acc) begin
          dvd_full <= 1'b1;
          dvd_buf  <= dif.s_axis_dividend_tdata;
        end
        if (dvs_acc) begin
          dvs_full <= 1'b1;
          dvs_buf  <= dif.s_axis_divisor_tdata;
        end
      end
      if (state == CALC) begin
        rem <= rem_nxt;
        quo <= quo_nxt;
        cnt <= cnt + CNT_W'(1);
        if (last_iter) begin
          dout_data <= {quo_nxt, rem_nxt};
          dout_zero <= (dvs_reg == '0);
        end
      end
    end
  end

  assign dif.s_axis_dividend_tready = dvd_rdy;
  assign dif.s_axis_divisor_tready  = dvs_rdy;
  assign dif.m_axis_dout_tvalid     = (state == DONE);
  assign dif.m_axis_dout_tdata      = dout_data;
  assign dif.m_axis_dout_tuser      = dout_zero;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider against an arithmetic reference.
module tb_seq_divider;

  localparam int W   = 64;
  localparam int LAT = W;     // edges from the completing-beat edge to the DONE edge
  localparam int PER = W + 2; // cycles between accepted operand pairs

  logic Clk = 1'b0;
  logic resetn = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  seq_divider_if #(.WIDTH(W)) dif ();

  seq_divider #(.WIDTH(W), .CNT_W(7)) dut (
    .Clk    (Clk),
    .resetn (resetn),
    .dif    (dif)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: {div_by_zero, quotient, remainder}
  function automatic logic [128:0] ref_div(input logic [63:0] a, input logic [63:0] b);
    if (b == 64'd0) return {1'b1, {64{1'b1}}, a};
    return {1'b0, a / b, a % b};
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_result(input string tag, input logic [128:0] exp);
    int n;
    n = 0;
    while (!dif.m_axis_dout_tvalid && n < 200) begin
      step();
      n++;
    end
    chk({tag, " latency"}, 128'(n), 128'(LAT));
    chk({tag, " tdata"}, dif.m_axis_dout_tdata, exp[127:0]);
    chk({tag, " tuser"}, 128'(dif.m_axis_dout_tuser), 128'(exp[128]));
    step();
    chk({tag, " strobe width"}, 128'(dif.m_axis_dout_tvalid), 128'd0);
    chk({tag, " tdata held"}, dif.m_axis_dout_tdata, exp[127:0]);
    chk({tag, " ready after"}, 128'({dif.s_axis_dividend_tready, dif.s_axis_divisor_tready}), 128'd3);
  endtask

  // Presents one division; gap>0 staggers the channels by that many cycles.
  task automatic do_div(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input int gap, input bit dvs_first);
    chk({tag, " ready idle"}, 128'({dif.s_axis_dividend_tready, dif.s_axis_divisor_tready}), 128'd3);
    if (gap == 0) begin
      dif.s_axis_dividend_tdata = a;  dif.s_axis_dividend_tvalid = 1'b1;
      dif.s_axis_divisor_tdata  = b;  dif.s_axis_divisor_tvalid  = 1'b1;
      step();
    end else begin
      if (dvs_first) begin dif.s_axis_divisor_tdata = b;  dif.s_axis_divisor_tvalid = 1'b1; end
      else           begin dif.s_axis_dividend_tdata = a; dif.s_axis_dividend_tvalid = 1'b1; end
      step();
      dif.s_axis_divisor_tvalid  = 1'b0;
      dif.s_axis_dividend_tvalid = 1'b0;
      for (int i = 0; i < gap; i++) begin
        // Buffered channel stays closed, the other stays open.
        chk({tag, " stagger ready"}, 128'({dif.s_axis_dividend_tready, dif.s_axis_divisor_tready}),
            dvs_first ? 128'd2 : 128'd1);
        if (i < gap - 1) step();
      end
      if (dvs_first) begin dif.s_axis_dividend_tdata = a; dif.s_axis_dividend_tvalid = 1'b1; end
      else           begin dif.s_axis_divisor_tdata = b;  dif.s_axis_divisor_tvalid  = 1'b1; end
      step();
    end
    dif.s_axis_dividend_tvalid = 1'b0;
    dif.s_axis_divisor_tvalid  = 1'b0;
    chk({tag, " ready calc"}, 128'({dif.s_axis_dividend_tready, dif.s_axis_divisor_tready}), 128'd0);
    wait_result(tag, ref_div(a, b));
  endtask

  function automatic logic [63:0] rnd64();
    return {32'($urandom), 32'($urandom)} >> $urandom_range(0, 63);
  endfunction

  initial begin
    logic [63:0] a, b;
    logic [128:0] exp_q[$];
    logic [127:0] last;
    logic [128:0] e;
    bit have_last, seen;

    dif.s_axis_dividend_tvalid = 1'b0;
    dif.s_axis_divisor_tvalid  = 1'b0;
    dif.s_axis_dividend_tdata  = '0;
    dif.s_axis_divisor_tdata   = '0;
    repeat (3) step();
    chk("reset tvalid", 128'(dif.m_axis_dout_tvalid), 128'd0);
    chk("reset tdata", dif.m_axis_dout_tdata, 128'd0);
    chk("reset tuser", 128'(dif.m_axis_dout_tuser), 128'd0);
    chk("reset ready", 128'({dif.s_axis_dividend_tready, dif.s_axis_divisor_tready}), 128'd3);
    resetn = 1'b1;
    step();

    do_div("100/7", 64'd100, 64'd7, 0, 1'b0);
    do_div("max/1", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, 1'b0);
    do_div("2^31/2^31", 64'h8000_0000, 64'h8000_0000, 0, 1'b0);
    do_div("div0", 64'h1234, 64'd0, 0, 1'b0);
    do_div("stagger dvs first", 64'd5000, 64'd13, 5, 1'b1);
    do_div("stagger dvd first", 64'd77, 64'd78, 3, 1'b0);

    // Reset in the middle of a run discards it.
    dif.s_axis_dividend_tdata = 64'd1000; dif.s_axis_dividend_tvalid = 1'b1;
    dif.s_axis_divisor_tdata  = 64'd3;    dif.s_axis_divisor_tvalid  = 1'b1;
    step();
    dif.s_axis_dividend_tvalid = 1'b0;
    dif.s_axis_divisor_tvalid  = 1'b0;
    repeat (20) step();
    resetn = 1'b0;
    step();
    chk("midrun reset tvalid", 128'(dif.m_axis_dout_tvalid), 128'd0);
    chk("midrun reset tdata", dif.m_axis_dout_tdata, 128'd0);
    chk("midrun reset ready", 128'({dif.s_axis_dividend_tready, dif.s_axis_divisor_tready}), 128'd3);
    resetn = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      step();
      if (dif.m_axis_dout_tvalid) seen = 1'b1;
    end
    chk("no strobe after reset", 128'(seen), 128'd0);
    chk("tdata zero after reset", dif.m_axis_dout_tdata, 128'd0);
    do_div("9/4", 64'd9, 64'd4, 0, 1'b0);

    for (int k = 0; k < 6; k++) begin
      a = rnd64();
      b = ($urandom_range(0, 5) == 0) ? 64'd0 : rnd64();
      do_div("random", a, b, $urandom_range(0, 4), 1'($urandom_range(0, 1)));
    end

    // Continuous traffic: new data every cycle, only IDLE-cycle beats are taken.
    have_last = 1'b0;
    last = '0;
    for (int s = 0; s < 4 * PER; s++) begin
      a = rnd64();
      b = ($urandom_range(0, 4) == 0) ? 64'd0 : rnd64();
      dif.s_axis_dividend_tdata = a; dif.s_axis_dividend_tvalid = 1'b1;
      dif.s_axis_divisor_tdata  = b; dif.s_axis_divisor_tvalid  = 1'b1;
      chk("stream ready", 128'({dif.s_axis_dividend_tready, dif.s_axis_divisor_tready}),
          (s % PER == 0) ? 128'd3 : 128'd0);
      chk("stream tvalid", 128'(dif.m_axis_dout_tvalid), 128'(s % PER == PER - 1));
      if (s % PER == PER - 1 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("stream tdata", dif.m_axis_dout_tdata, e[127:0]);
        chk("stream tuser", 128'(dif.m_axis_dout_tuser), 128'(e[128]));
        last = e[127:0];
        have_last = 1'b1;
      end else if (have_last) begin
        chk("stream tdata stable", dif.m_axis_dout_tdata, last);
      end
      if (s % PER == 0) exp_q.push_back(ref_div(a, b));
      step();
    end
    dif.s_axis_dividend_tvalid = 1'b0;
    dif.s_axis_divisor_tvalid  = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
